// File: rtl/mul_sched_pkg.sv
// Shared decode constants, tag type and mul-op decoder for the multiplier scheduler.
// The MUL* match/mask words are composed from the OP opcode and MULDIV funct7 fields.
package mul_sched_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;

    localparam logic [31:0] IM__MUL    = {7'h7f, 10'h000, 3'b111, 5'h00, 7'h7f};
    localparam logic [31:0] IM__MULH   = IM__MUL;
    localparam logic [31:0] IM__MULHSU = IM__MUL;
    localparam logic [31:0] IM__MULHU  = IM__MUL;

    localparam logic [31:0] I__MUL     = {F7_MULDIV, 10'h000, F3_MUL,    5'h00, OPC_OP};
    localparam logic [31:0] I__MULH    = {F7_MULDIV, 10'h000, F3_MULH,   5'h00, OPC_OP};
    localparam logic [31:0] I__MULHSU  = {F7_MULDIV, 10'h000, F3_MULHSU, 5'h00, OPC_OP};
    localparam logic [31:0] I__MULHU   = {F7_MULDIV, 10'h000, F3_MULHU,  5'h00, OPC_OP};

    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_MUL,
        MOP_MULH,
        MOP_MULHSU,
        MOP_MULHU
    } mul_op_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } tag_t;

    function automatic mul_op_e decode_mul(input logic [31:0] insn);
        mul_op_e op;
        op = MOP_NONE;
        if ((insn & IM__MUL) == I__MUL)
            op = MOP_MUL;
        else if ((insn & IM__MULH) == I__MULH)
            op = MOP_MULH;
        else if ((insn & IM__MULHSU) == I__MULHSU)
            op = MOP_MULHSU;
        else if ((insn & IM__MULHU) == I__MULHU)
            op = MOP_MULHU;
        return op;
    endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Two-entry {v, rd} tag pipe mirroring the multiplier stages, with hold/flush
// and a source-match output used for RAW stall detection.
module mul_tag_pipe
    import mul_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       flush,
    input  logic       load_v,
    input  logic [4:0] load_rd,
    input  logic [4:0] ra,
    input  logic [4:0] rb,
    output logic       s1_v,
    output logic [4:0] s1_rd,
    output logic       s2_v,
    output logic [4:0] s2_rd,
    output logic       hit
);

    tag_t s1;
    tag_t s2;

    // Flush clears only the valid bits, and wins over hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (!hold) begin
                s2 <= s1;
                s1 <= '{v: load_v, rd: load_rd};
            end
            if (flush) begin
                s1.v <= 1'b0;
                s2.v <= 1'b0;
            end
        end
    end

    function automatic logic tag_match(input tag_t t, input logic [4:0] a, input logic [4:0] b);
        return t.v && (t.rd != 5'd0) && ((t.rd == a) || (t.rd == b));
    endfunction

    always_comb begin
        hit = tag_match(s1, ra, rb) || tag_match(s2, ra, rb);
    end

    assign s1_v  = s1.v;
    assign s1_rd = s1.rd;
    assign s2_v  = s2.v;
    assign s2_rd = s2.rd;

endmodule

// File: rtl/mul_sched.sv
// Issue/writeback scheduler for the 2-stage multiplier: decodes MUL ops, stalls
// RAW-dependent issues and emits writeback strobes aligned with wb_value.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] issue_opcode,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_ra,
    input  logic [4:0]  issue_rb,
    input  logic        hold,
    input  logic        flush,
    output logic        issue_ready,
    output logic        mul_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_next,
    output logic [1:0]  inflight
);

    if (MULT_STAGES != 2) begin : g_bad_stages
        $error("mul_sched supports only MULT_STAGES == 2");
    end

    mul_op_e    op;
    logic       is_mul;
    logic       hit;
    logic       haz;
    logic       s1_v;
    logic       s2_v;
    logic [4:0] s1_rd;
    logic [4:0] s2_rd;

    always_comb begin
        op     = decode_mul(issue_opcode);
        is_mul = (op != MOP_NONE);
    end

    // Only mul ops stall here; the main pipe resolves hazards for everything else.
    always_comb begin
        haz         = is_mul && hit;
        issue_ready = !hold && !flush && !haz;
        mul_valid   = issue_valid && is_mul && issue_ready;
    end

    mul_tag_pipe u_tags (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .flush   (flush),
        .load_v  (mul_valid),
        .load_rd (issue_rd),
        .ra      (issue_ra),
        .rb      (issue_rb),
        .s1_v    (s1_v),
        .s1_rd   (s1_rd),
        .s2_v    (s2_v),
        .s2_rd   (s2_rd),
        .hit     (hit)
    );

    always_comb begin
        wb_valid = s2_v && !hold && !flush;
        wb_rd    = s2_rd;
        wb_next  = s1_v;
        inflight = {1'b0, s1_v} + {1'b0, s2_v};
    end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed scenarios then random traffic,
// compared against an accept-timestamp model of in-flight multiplies.
module tb_mul_sched;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_opcode;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_ra;
    logic [4:0]  issue_rb;
    logic        hold;
    logic        flush;
    logic        issue_ready;
    logic        mul_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_next;
    logic [1:0]  inflight;

    int vectors;
    int miscompares;

    mul_sched #(.MULT_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_rd     (issue_rd),
        .issue_ra     (issue_ra),
        .issue_rb     (issue_rb),
        .hold         (hold),
        .flush        (flush),
        .issue_ready  (issue_ready),
        .mul_valid    (mul_valid),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_next      (wb_next),
        .inflight     (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every accepted mul is stamped with the count of non-held edges seen
    // so far; its age is how many non-held edges it has travelled since issue.
    typedef struct {
        logic [4:0] rd;
        int         stamp;
    } op_t;

    op_t q[$];
    int  eff;

    logic exp_ready;
    logic exp_mv;
    logic exp_wbv;
    logic exp_next;
    logic exp_is_mul;
    logic exp_haz;
    logic have_wb;
    logic [4:0] exp_wbrd;
    int   exp_cnt;

    task check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] make_insn(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [4:0] ra,
                                              input logic [4:0] rb, input logic [6:0] opc);
        return {f7, rb, ra, f3, rd, opc};
    endfunction

    // One cycle: drive inputs just after the edge, optionally pulse reset, check
    // mid-cycle, then advance the model across the next rising edge.
    task apply_stimulus(input logic v, input logic [31:0] opc, input logic [4:0] rd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic h, input logic f, input logic r);
        issue_valid  = v;
        issue_opcode = opc;
        issue_rd     = rd;
        issue_ra     = ra;
        issue_rb     = rb;
        hold         = h;
        flush        = f;
        if (r) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
            q.delete();
        end
        @(negedge clk);
        exp_is_mul = (opc[6:0] == 7'b0110011) && (opc[31:25] == 7'b0000001) && (opc[14:12] < 3'd4);
        exp_haz  = 1'b0;
        exp_next = 1'b0;
        have_wb  = 1'b0;
        exp_wbrd = 5'd0;
        foreach (q[i]) begin
            if (q[i].rd != 5'd0 && (q[i].rd == ra || q[i].rd == rb))
                exp_haz = exp_is_mul;
            if (eff - q[i].stamp == 1)
                exp_next = 1'b1;
            if (eff - q[i].stamp == 2) begin
                have_wb  = 1'b1;
                exp_wbrd = q[i].rd;
            end
        end
        exp_cnt   = q.size();
        exp_ready = !h && !f && !exp_haz;
        exp_mv    = v && exp_is_mul && exp_ready;
        exp_wbv   = have_wb && !h && !f;
        check_output("issue_ready", {7'd0, issue_ready}, {7'd0, exp_ready});
        check_output("mul_valid",   {7'd0, mul_valid},   {7'd0, exp_mv});
        check_output("wb_valid",    {7'd0, wb_valid},    {7'd0, exp_wbv});
        check_output("wb_next",     {7'd0, wb_next},     {7'd0, exp_next});
        check_output("inflight",    {6'd0, inflight},    exp_cnt[7:0]);
        if (have_wb)
            check_output("wb_rd", {3'd0, wb_rd}, {3'd0, exp_wbrd});
        @(posedge clk);
        if (!h) begin
            if (exp_mv)
                q.push_back('{rd: rd, stamp: eff});
            eff++;
        end
        if (f)
            q.delete();
        for (int i = q.size() - 1; i >= 0; i--)
            if (eff - q[i].stamp > 2)
                q.delete(i);
        #1;
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] rnd_insn;
    logic [2:0]  rnd_f3;
    logic [4:0]  r_rd;
    logic [4:0]  r_ra;
    logic [4:0]  r_rb;
    int          sel;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        eff          = 0;
        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_opcode = 32'h0;
        issue_rd     = 5'd0;
        issue_ra     = 5'd0;
        issue_rb     = 5'd0;
        hold         = 1'b0;
        flush        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        #2;
        check_output("reset wb_valid",    {7'd0, wb_valid},    8'd0);
        check_output("reset wb_rd",       {3'd0, wb_rd},       8'd0);
        check_output("reset wb_next",     {7'd0, wb_next},     8'd0);
        check_output("reset inflight",    {6'd0, inflight},    8'd0);
        check_output("reset issue_ready", {7'd0, issue_ready}, 8'd1);
        @(posedge clk);
        #1;

        $display("[TB] single MUL rd=5");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd5, 5'd1, 5'd2, 7'h33), 5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] back-to-back MULH rd=3, MULHU rd=4");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b001, 5'd3, 5'd1, 5'd2, 7'h33), 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b011, 5'd4, 5'd1, 5'd2, 7'h33), 5'd4, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] RAW stall on rd=7");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd7, 5'd1, 5'd2, 7'h33), 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd8, 5'd7, 5'd2, 7'h33), 5'd8, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] rd=0 producer, no stall");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd0, 5'd3, 5'd4, 7'h33), 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b010, 5'd6, 5'd0, 5'd0, 7'h33), 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] hold for two cycles after issue");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd9, 5'd1, 5'd2, 7'h33), 5'd9, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd10, 5'd1, 5'd2, 7'h33), 5'd10, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(4);

        $display("[TB] flush with two in flight");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd11, 5'd1, 5'd2, 7'h33), 5'd11, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b001, 5'd12, 5'd1, 5'd2, 7'h33), 5'd12, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd13, 5'd1, 5'd2, 7'h33), 5'd13, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        idle(4);

        $display("[TB] reset pulsed mid-flight");
        apply_stimulus(1'b1, make_insn(7'h01, 3'b000, 5'd14, 5'd1, 5'd2, 7'h33), 5'd14, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, make_insn(7'h01, 3'b011, 5'd15, 5'd1, 5'd2, 7'h33), 5'd15, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(4);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            r_rd = 5'($urandom_range(0, 7));
            r_ra = 5'($urandom_range(0, 7));
            r_rb = 5'($urandom_range(0, 7));
            sel  = $urandom_range(0, 9);
            if (sel < 6) begin
                rnd_f3   = 3'($urandom_range(0, 3));
                rnd_insn = make_insn(7'h01, rnd_f3, r_rd, r_ra, r_rb, 7'h33);
            end else if (sel == 6) begin
                rnd_insn = make_insn(7'h00, 3'b000, r_rd, r_ra, r_rb, 7'h33);
            end else if (sel == 7) begin
                rnd_f3   = 3'($urandom_range(4, 7));
                rnd_insn = make_insn(7'h01, rnd_f3, r_rd, r_ra, r_rb, 7'h33);
            end else if (sel == 8) begin
                rnd_insn = make_insn(7'h01, 3'b000, r_rd, r_ra, r_rb, 7'h3b);
            end else begin
                rnd_insn = $urandom;
            end
            apply_stimulus($urandom_range(0, 3) != 0, rnd_insn, r_rd, r_ra, r_rb,
                           $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0,
                           $urandom_range(0, 59) == 0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_sched.md
# mul_sched

Issue and writeback scheduler for the 2-stage pipelined `multiplier`. It decodes MUL/MULH/MULHSU/MULHU ops from the issue stage and gates them into the multiplier's `Valid` input. It tracks destination tags through the multiplier pipeline and stalls dependent issues (RAW on in-flight results). It also emits `wb_valid`/`wb_rd`, aligned cycle-for-cycle with the multiplier's `wb_value`, to the register-file write port.

## Interface
Parameters:
- `MULT_STAGES`, 2: multiplier latency in cycles from accepted issue to `wb_value` valid. Only 2 is supported.

Ports:
- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `issue_valid`  in  1  issue stage presents an instruction.
- `issue_opcode`  in  32  instruction word.
- `issue_rd`, `issue_ra`, `issue_rb`  in  5 each  destination and source register indices.
- `hold`  in  1  pipeline freeze; same signal drives the multiplier's `hold`.
- `flush`  in  1  kill all in-flight multiplies.
- `issue_ready`  out  1  scheduler accepts the presented op this cycle.
- `mul_valid`  out  1  drives the multiplier `Valid`.
- `wb_valid`  out  1  the multiplier's `wb_value` is to be written this cycle.
- `wb_rd`  out  5  destination index for `wb_value`.
- `wb_next`  out  1  a writeback will occur next non-held cycle (s1 occupied).
- `inflight`  out  2  number of valid tags in s1+s2 (0..2).

## Operation
- Decode: `is_mul` = opcode[6:0]==7'b0110011, funct7==7'b0000001, funct3 in {000,001,010,011}. Masks and matches come from the shared `I__MUL*`/`IM__MUL*` constants.
- Tag pipe: two entries, `s1` and `s2`, each {v, rd}.
  - `s1` = op whose operands are latched in the multiplier.
  - `s2` = op whose result is in `result_1`.
- Hazard: `haz` = is_mul & ((s1.v & s1.rd!=0 & (s1.rd==issue_ra | s1.rd==issue_rb)) | (s2.v & s2.rd!=0 & (s2.rd==issue_ra | s2.rd==issue_rb))).
  - No bypass. Applies only to mul ops; non-mul hazards belong to the main pipe.
- `issue_ready` = ~hold & ~flush & ~haz. It is 1 for non-mul ops unless hold/flush is asserted.
- `mul_valid` = issue_valid & is_mul & issue_ready.
- On each edge with ~hold:
  - s2 <= s1.
  - s1 <= {mul_valid, issue_rd}.
- On an edge with hold: s1 and s2 are retained.
- Flush: on an edge with flush, s1.v and s2.v are cleared. Flush has priority over hold.
- `wb_valid` = s2.v & ~hold & ~flush, and `wb_rd` = s2.rd. An op with rd=0 still occupies the tag pipe and raises `wb_valid`; the register file ignores x0.
- `wb_next` = s1.v; `inflight` = s1.v + s2.v.

## Timing
- Reset values:
  - s1, s2 = 0; `wb_valid`=0, `wb_rd`=0, `wb_next`=0, `inflight`=0.
  - `issue_ready`=1 when hold=0 and flush=0. `mul_valid` follows issue inputs combinationally.
- Latency: an op accepted in cycle T with no hold gives `wb_valid`=1 in cycle T+2, coincident with the multiplier `wb_value`. Each held cycle adds one cycle.
- Throughput: one independent mul per cycle. A dependent mul issues in cycle T+3 at the earliest (the producer's tag leaves s2 at the T+3 edge).
- Simultaneous issue and writeback to the same rd: allowed if there is no source hazard (WAW ordering is preserved by the pipe).
- Hold during writeback: `wb_valid` is suppressed while held. It reasserts in the first non-held cycle with unchanged `wb_rd`.
- Reset mid-operation: all tags are dropped immediately (asynchronous). No writeback occurs for ops in flight at reset.

## Structure
- `defs.v` (shared): `I__MUL`, `IM__MUL`, `I__MULH`, `IM__MULH`, `I__MULHSU`, `IM__MULHSU`, `I__MULHU`, `IM__MULHU`, and the OP opcode / MULDIV funct7 constants. No new local opcode literals.
- Sub-module `mul_tag_pipe`: the 2-entry {v, rd} shift register with hold/flush and the hazard-compare outputs. `mul_sched` holds the decode, ready/valid gating and output logic.

## Test plan
- Single MUL, rd=5, ra=1, rb=2, issued in cycle 0 with no hold -> `mul_valid`=1 in cycle 0; `wb_valid`=1 and `wb_rd`=5 in cycle 2 only; `inflight` reads 1,1,0 in cycles 1,2,3.
- Back-to-back independent MULH rd=3 then MULHU rd=4 -> `issue_ready`=1 both cycles; `wb_valid` in cycles 2 and 3 with `wb_rd` 3 then 4.
- MUL rd=7, then in cycle 1 MUL with ra=7 -> `issue_ready`=0 in cycles 1 and 2, accepted in cycle 3, its `wb_valid` in cycle 5.
- Dependent op with rd=0 producer (MUL rd=0, next op ra=0) -> no stall; producer still raises `wb_valid` with `wb_rd`=0.
- hold asserted in cycles 1-2 after issue in cycle 0 -> s1 retained, `issue_ready`=0 while held, `wb_valid` asserts in cycle 4.
- flush in cycle 1 with two ops in flight; separately, `rst` pulsed mid-flight -> no `wb_valid` afterward, `inflight`=0, `issue_ready`=1 in the first free cycle.
